ysyx_22050550_trap_ctrl: RTL and testbench

Trap sequencer between the write-back stage and the CSR file. It watches retiring instructions for ecall, mret and an enabled machine-timer interrupt. When one occurs, it stalls retirement, issues one CSR write cycle using the CSR-file write-enable encoding, then holds a redirect/flush request until the fetch side accepts it. It is the only agent that performs trap-entry and trap-return CSR updates; the write-back stage handles Zicsr writes only.

---
 rtl/ysyx_22050550_trap_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ysyx_22050550_trap_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050550_trap_ctrl.sv
// Trap sequencer between write-back and the CSR file: detects ecall/mret/timer irq,
// issues one CSR write cycle, then holds a redirect+flush until fetch accepts it.
module ysyx_22050550_trap_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_WB_valid,
    output logic            io_WB_ready,
    input  logic [XLEN-1:0] io_WB_pc,
    input  logic [XLEN-1:0] io_WB_NextPc,
    input  logic            io_WB_ecall,
    input  logic            io_WB_mret,
    input  logic            io_irq_mtip,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic [7:0]      trap_csren,
    output logic [XLEN-1:0] trap_mepc,
    output logic [XLEN-1:0] trap_mcause,
    output logic [XLEN-1:0] trap_mstatus,
    output logic            io_redirect_valid,
    input  logic            io_redirect_ready,
    output logic [XLEN-1:0] io_redirect_pc,
    output logic            io_flush,
    output logic            io_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] MCAUSE_ECALL = XLEN'(64'h0000_0000_0000_000b);
    localparam logic [XLEN-1:0] MCAUSE_MTI   = XLEN'(64'h8000_0000_0000_0007);
    localparam logic [7:0]      CSREN_TRAP   = 8'b0000_1011;
    localparam logic [7:0]      CSREN_RET    = 8'b0000_1000;

    // Trap entry: stack MIE into MPIE, disable interrupts, enter M-mode.
    function automatic logic [XLEN-1:0] trap_mstatus_f(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r        = ms;
        r[7]     = ms[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE and set MPIE.
    function automatic logic [XLEN-1:0] ret_mstatus_f(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r    = ms;
        r[3] = ms[7];
        r[7] = 1'b1;
        return r;
    endfunction

    state_t          state_r;
    logic [XLEN-1:0] target_r;

    logic            accept_s;
    logic            irq_take_s;
    logic            ev_trap_s;
    logic            ev_ret_s;
    logic [XLEN-1:0] ev_mepc_s;
    logic [XLEN-1:0] ev_mcause_s;
    logic [XLEN-1:0] ev_mstatus_s;
    logic [XLEN-1:0] ev_target_s;
    logic            unused_ok_s;

    assign unused_ok_s = ^{mie[XLEN-1:8], mie[6:0], mtvec[1:0]};

    // Event decode with ecall > mret > timer interrupt priority.
    always_comb begin
        accept_s     = io_WB_valid & io_WB_ready;
        irq_take_s   = io_irq_mtip & mstatus[3] & mie[7];
        ev_trap_s    = 1'b0;
        ev_ret_s     = 1'b0;
        ev_mepc_s    = '0;
        ev_mcause_s  = '0;
        ev_mstatus_s = '0;
        ev_target_s  = '0;
        if (io_WB_ecall) begin
            ev_trap_s    = 1'b1;
            ev_mepc_s    = io_WB_pc;
            ev_mcause_s  = MCAUSE_ECALL;
            ev_mstatus_s = trap_mstatus_f(mstatus);
            ev_target_s  = {mtvec[XLEN-1:2], 2'b00};
        end else if (io_WB_mret) begin
            ev_ret_s     = 1'b1;
            ev_mstatus_s = ret_mstatus_f(mstatus);
            ev_target_s  = mepc;
        end else if (irq_take_s) begin
            ev_trap_s    = 1'b1;
            ev_mepc_s    = io_WB_NextPc;
            ev_mcause_s  = MCAUSE_MTI;
            ev_mstatus_s = trap_mstatus_f(mstatus);
            ev_target_s  = {mtvec[XLEN-1:2], 2'b00};
        end else begin
            ev_trap_s = 1'b0;
        end
    end

    // Sequencer FSM; all outputs are registered and cleared outside their state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r           <= ST_IDLE;
            target_r          <= '0;
            io_WB_ready       <= 1'b1;
            io_busy           <= 1'b0;
            trap_csren        <= 8'h00;
            trap_mepc         <= '0;
            trap_mcause       <= '0;
            trap_mstatus      <= '0;
            io_redirect_valid <= 1'b0;
            io_redirect_pc    <= '0;
            io_flush          <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (ev_trap_s || ev_ret_s)) begin
                        state_r      <= ST_WRITE;
                        io_WB_ready  <= 1'b0;
                        io_busy      <= 1'b1;
                        trap_csren   <= ev_trap_s ? CSREN_TRAP : CSREN_RET;
                        trap_mepc    <= ev_mepc_s;
                        trap_mcause  <= ev_mcause_s;
                        trap_mstatus <= ev_mstatus_s;
                        target_r     <= ev_target_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    state_r           <= ST_REDIR;
                    trap_csren        <= 8'h00;
                    trap_mepc         <= '0;
                    trap_mcause       <= '0;
                    trap_mstatus      <= '0;
                    io_redirect_valid <= 1'b1;
                    io_flush          <= 1'b1;
                    io_redirect_pc    <= target_r;
                end
                ST_REDIR: begin
                    if (io_redirect_ready) begin
                        state_r           <= ST_IDLE;
                        io_redirect_valid <= 1'b0;
                        io_flush          <= 1'b0;
                        io_redirect_pc    <= '0;
                        io_WB_ready       <= 1'b1;
                        io_busy           <= 1'b0;
                        target_r          <= '0;
                    end else begin
                        state_r <= ST_REDIR;
                    end
                end
                default: begin
                    state_r           <= ST_IDLE;
                    target_r          <= '0;
                    io_WB_ready       <= 1'b1;
                    io_busy           <= 1'b0;
                    trap_csren        <= 8'h00;
                    trap_mepc         <= '0;
                    trap_mcause       <= '0;
                    trap_mstatus      <= '0;
                    io_redirect_valid <= 1'b0;
                    io_redirect_pc    <= '0;
                    io_flush          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050550_trap_ctrl.sv
// Bench for ysyx_22050550_trap_ctrl: transaction-level model checked every negedge,
// plus directed scenarios with hand-computed literal expectations.
module tb_ysyx_22050550_trap_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_WB_valid = 1'b0;
    logic        io_WB_ready;
    logic [63:0] io_WB_pc = 64'h0;
    logic [63:0] io_WB_NextPc = 64'h0;
    logic        io_WB_ecall = 1'b0;
    logic        io_WB_mret = 1'b0;
    logic        io_irq_mtip = 1'b0;
    logic [63:0] mstatus = 64'h0;
    logic [63:0] mie = 64'h0;
    logic [63:0] mtvec = 64'h0;
    logic [63:0] mepc = 64'h0;
    logic [7:0]  trap_csren;
    logic [63:0] trap_mepc, trap_mcause, trap_mstatus;
    logic        io_redirect_valid;
    logic        io_redirect_ready = 1'b1;
    logic [63:0] io_redirect_pc;
    logic        io_flush;
    logic        io_busy;

    int checks = 0;
    int errors = 0;

    ysyx_22050550_trap_ctrl dut (
        .clock(clock), .reset(reset),
        .io_WB_valid(io_WB_valid), .io_WB_ready(io_WB_ready),
        .io_WB_pc(io_WB_pc), .io_WB_NextPc(io_WB_NextPc),
        .io_WB_ecall(io_WB_ecall), .io_WB_mret(io_WB_mret),
        .io_irq_mtip(io_irq_mtip),
        .mstatus(mstatus), .mie(mie), .mtvec(mtvec), .mepc(mepc),
        .trap_csren(trap_csren), .trap_mepc(trap_mepc),
        .trap_mcause(trap_mcause), .trap_mstatus(trap_mstatus),
        .io_redirect_valid(io_redirect_valid), .io_redirect_ready(io_redirect_ready),
        .io_redirect_pc(io_redirect_pc), .io_flush(io_flush), .io_busy(io_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Model: a pending request ages from its write cycle (1) to its redirect cycles (2).
    bit          m_busy = 1'b0;
    int          m_age = 0;
    bit          m_trap = 1'b0;
    logic [63:0] m_mepc = 64'h0, m_mcause = 64'h0, m_mst = 64'h0, m_tgt = 64'h0;

    wire         m_irq   = io_irq_mtip && mstatus[3] && mie[7];
    wire         m_event = io_WB_ecall || io_WB_mret || m_irq;
    wire         m_is_trap = io_WB_ecall || !io_WB_mret;
    wire [63:0]  m_trap_st = (mstatus & ~64'h1888) | 64'h1800 | (mstatus[3] ? 64'h80 : 64'h0);
    wire [63:0]  m_ret_st  = (mstatus & ~64'h88) | 64'h80 | (mstatus[7] ? 64'h8 : 64'h0);

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_age  <= 0;
        end else if (!m_busy) begin
            if (io_WB_valid && m_event) begin
                m_busy   <= 1'b1;
                m_age    <= 1;
                m_trap   <= m_is_trap;
                m_mepc   <= io_WB_ecall ? io_WB_pc : io_WB_NextPc;
                m_mcause <= io_WB_ecall ? 64'hb : 64'h8000_0000_0000_0007;
                m_mst    <= m_is_trap ? m_trap_st : m_ret_st;
                m_tgt    <= m_is_trap ? (mtvec & ~64'h3) : mepc;
            end
        end else if (m_age == 1) begin
            m_age <= 2;
        end else if (io_redirect_ready) begin
            m_busy <= 1'b0;
        end
    end

    // Compare process on every falling edge.
    always @(negedge clock) begin
        bit in_w, in_r;
        in_w = m_busy && (m_age == 1);
        in_r = m_busy && (m_age == 2);
        chk("ready", {63'h0, io_WB_ready}, {63'h0, !m_busy});
        chk("busy", {63'h0, io_busy}, {63'h0, m_busy});
        chk("csren", {56'h0, trap_csren}, in_w ? (m_trap ? 64'h0b : 64'h08) : 64'h0);
        chk("mstatus_w", trap_mstatus, in_w ? m_mst : 64'h0);
        if (!in_w || m_trap) begin
            chk("mepc_w", trap_mepc, in_w ? m_mepc : 64'h0);
            chk("mcause_w", trap_mcause, in_w ? m_mcause : 64'h0);
        end
        chk("redir_valid", {63'h0, io_redirect_valid}, {63'h0, in_r});
        chk("flush", {63'h0, io_flush}, {63'h0, in_r});
        chk("redir_pc", io_redirect_pc, in_r ? m_tgt : 64'h0);
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    // Present one retirement for one cycle; returns #1 after the following negedge.
    task automatic retire(input logic [63:0] pc, input logic [63:0] npc,
                          input logic ec, input logic mr);
        step();
        io_WB_valid  = 1'b1;
        io_WB_pc     = pc;
        io_WB_NextPc = npc;
        io_WB_ecall  = ec;
        io_WB_mret   = mr;
        step();
        io_WB_valid = 1'b0;
        io_WB_ecall = 1'b0;
        io_WB_mret  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clock);
        #1;
        chk("rst_ready", {63'h0, io_WB_ready}, 64'h1);
        chk("rst_csren", {56'h0, trap_csren}, 64'h0);
        reset = 1'b1;
        step();
        chk("idle_rv", {63'h0, io_redirect_valid}, 64'h0);
        chk("idle_busy", {63'h0, io_busy}, 64'h0);

        // ecall
        mstatus = 64'h8; mtvec = 64'h8000_0101;
        retire(64'h8000_0010, 64'h8000_0014, 1'b1, 1'b0);
        chk("ec_csren", {56'h0, trap_csren}, 64'h0b);
        chk("ec_mepc", trap_mepc, 64'h8000_0010);
        chk("ec_mcause", trap_mcause, 64'hb);
        chk("ec_mstatus", trap_mstatus, 64'h1880);
        step();
        chk("ec_pc", io_redirect_pc, 64'h8000_0100);
        chk("ec_flush", {63'h0, io_flush}, 64'h1);
        chk("ec_ready", {63'h0, io_WB_ready}, 64'h0);
        step();
        chk("ec_back", {63'h0, io_WB_ready}, 64'h1);

        // mret
        mstatus = 64'h1880; mepc = 64'h8000_0014;
        retire(64'h8000_0100, 64'h8000_0104, 1'b0, 1'b1);
        chk("mr_csren", {56'h0, trap_csren}, 64'h08);
        chk("mr_mstatus", trap_mstatus, 64'h1888);
        step();
        chk("mr_pc", io_redirect_pc, 64'h8000_0014);
        step();

        // timer interrupt taken, then suppressed by MTIE=0
        mstatus = 64'h8; mie = 64'h80; io_irq_mtip = 1'b1;
        retire(64'h8000_003c, 64'h8000_0040, 1'b0, 1'b0);
        chk("ti_mepc", trap_mepc, 64'h8000_0040);
        chk("ti_mcause", trap_mcause, 64'h8000_0000_0000_0007);
        step();
        chk("ti_pc", io_redirect_pc, 64'h8000_0100);
        step();
        mie = 64'h0;
        retire(64'h8000_0040, 64'h8000_0044, 1'b0, 1'b0);
        chk("ti_off_busy", {63'h0, io_busy}, 64'h0);
        chk("ti_off_csren", {56'h0, trap_csren}, 64'h0);

        // ecall wins over pending irq; then MIE=0 blocks the interrupt
        mie = 64'h80;
        retire(64'h8000_0050, 64'h8000_0054, 1'b1, 1'b0);
        chk("pri_mcause", trap_mcause, 64'hb);
        chk("pri_mepc", trap_mepc, 64'h8000_0050);
        step();
        step();
        mstatus = 64'h1880;
        retire(64'h8000_0100, 64'h8000_0104, 1'b0, 1'b0);
        chk("pri_noirq", {63'h0, io_busy}, 64'h0);
        io_irq_mtip = 1'b0;

        // backpressure with retirements ignored, then reset mid-redirect
        mstatus = 64'h8; io_redirect_ready = 1'b0;
        retire(64'h8000_0060, 64'h8000_0064, 1'b1, 1'b0);
        step();
        io_WB_valid = 1'b1; io_WB_ecall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {63'h0, io_redirect_valid}, 64'h1);
            chk("bp_flush", {63'h0, io_flush}, 64'h1);
            chk("bp_pc", io_redirect_pc, 64'h8000_0100);
            chk("bp_ready", {63'h0, io_WB_ready}, 64'h0);
            step();
        end
        io_WB_valid = 1'b0; io_WB_ecall = 1'b0;
        reset = 1'b0;
        #1;
        chk("ar_valid", {63'h0, io_redirect_valid}, 64'h0);
        chk("ar_flush", {63'h0, io_flush}, 64'h0);
        chk("ar_pc", io_redirect_pc, 64'h0);
        chk("ar_ready", {63'h0, io_WB_ready}, 64'h1);
        chk("ar_busy", {63'h0, io_busy}, 64'h0);
        step();
        reset = 1'b1; io_redirect_ready = 1'b1;
        step();
        chk("post_rst_valid", {63'h0, io_redirect_valid}, 64'h0);

        // single-cycle redirect after reset recovery
        retire(64'h8000_0070, 64'h8000_0074, 1'b1, 1'b0);
        chk("fin_mepc", trap_mepc, 64'h8000_0070);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
